// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//
// Shares one SRAM-like CPU bus between the instruction-fetch port and the
// data-access port, with at most one outstanding transaction. A winner is
// latched when a transaction is granted. Its request is driven onto the bus
// and addr_ok/data_ok are routed back to it only. Data normally wins ties. A
// consecutive-data-grant counter bounds how long a pending fetch can starve.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   inst_req/inst_addr        fetch request (held until inst_addr_ok)
//   inst_addr_ok/data_ok      fetch handshake pulses back to the fetch stage
//   inst_rdata                bus read data (valid with inst_data_ok)
//   data_req/wr/wstrb/addr/wdata  load/store request from the memory stage
//   data_addr_ok/data_ok      data handshake pulses back to the memory stage
//   data_rdata                bus read data (valid with data_data_ok)
//   bus_req/wr/wstrb/addr/wdata   request toward the cache / AXI bridge
//   bus_addr_ok/data_ok/rdata response from the cache / AXI bridge
//   bus_owner                 0 = inst, 1 = data (current or last grant)

module mem_bus_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        bus_req,
    output logic        bus_wr,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_addr_ok,
    input  logic        bus_data_ok,
    input  logic [31:0] bus_rdata,
    output logic        bus_owner
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             owner;
    logic             owner_nxt;
    logic [CNT_W-1:0] starve_cnt;
    logic [CNT_W-1:0] starve_cnt_nxt;
    logic             any_req;
    logic             pick_data;
    logic             grant;

    // Data wins any tie unless the fetch port has already watched
    // STARVE_LIMIT data grants in a row go past it.
    assign any_req   = inst_req | data_req;
    assign pick_data = data_req & ~(inst_req & (starve_cnt == CNT_MAX));

    // Read data is not registered; each requester captures it on its own
    // data_ok, so both ports simply see the bus data.
    assign inst_rdata = bus_rdata;
    assign data_rdata = bus_rdata;

    // State, owner and starvation counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= 1'b0;
            starve_cnt <= '0;
        end else begin
            state      <= state_nxt;
            owner      <= owner_nxt;
            starve_cnt <= starve_cnt_nxt;
        end
    end

    // Next-state, arbitration and output decode. Arbitration only happens
    // when leaving IDLE or when a response closes the transaction in WAIT,
    // so the owner is locked for the whole REQ/WAIT window. All outputs are
    // forced low while rst is high so a response arriving in the reset cycle
    // is never forwarded.
    always_comb begin
        state_nxt      = state;
        owner_nxt      = owner;
        starve_cnt_nxt = starve_cnt;
        grant          = 1'b0;

        bus_req      = 1'b0;
        bus_wr       = 1'b0;
        bus_wstrb    = 4'b0000;
        bus_addr     = 32'h0;
        bus_wdata    = 32'h0;
        bus_owner    = 1'b0;
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;

        case (state)
            IDLE: begin
                if (any_req) begin
                    grant     = 1'b1;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (bus_addr_ok) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (bus_data_ok) begin
                    if (any_req) begin
                        grant     = 1'b1;
                        state_nxt = REQ;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        if (grant) begin
            owner_nxt = pick_data;
            if (pick_data && inst_req) begin
                if (starve_cnt != CNT_MAX) begin
                    starve_cnt_nxt = starve_cnt + CNT_W'(1);
                end
            end else begin
                starve_cnt_nxt = '0;
            end
        end

        if (!rst) begin
            bus_owner = owner;
            if (state == REQ) begin
                bus_req = 1'b1;
                if (owner) begin
                    bus_wr       = data_wr;
                    bus_wstrb    = data_wstrb;
                    bus_addr     = data_addr;
                    bus_wdata    = data_wdata;
                    data_addr_ok = bus_addr_ok;
                end else begin
                    bus_addr     = inst_addr;
                    inst_addr_ok = bus_addr_ok;
                end
            end
            if (state == WAIT) begin
                if (owner) begin
                    data_data_ok = bus_data_ok;
                end else begin
                    inst_data_ok = bus_data_ok;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter
//
// Directed self-checking bench for mem_bus_arbiter. A table of one-cycle
// vectors covers reset, single transactions and stray responses, followed by
// hand-written sequences for the multi-cycle corners: fetch read data,
// store field routing, grant lock, starvation order, back-to-back throughput
// and reset in the middle of a transaction.

module tb_mem_bus_arbiter;

    localparam int STARVE_LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req;
    logic        data_wr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic        bus_req;
    logic        bus_wr;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_addr_ok;
    logic        bus_data_ok;
    logic [31:0] bus_rdata;
    logic        bus_owner;

    int compared   = 0;
    int mismatched = 0;

    // One cycle of stimulus: inputs plus expected
    // {bus_req, inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok, bus_owner}.
    typedef struct {
        logic       rst;
        logic       ireq;
        logic       dreq;
        logic       aok;
        logic       dok;
        logic [5:0] exp;
    } vec_t;

    vec_t tbl[13];

    mem_bus_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk          (clk),
        .rst          (rst),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_wstrb   (data_wstrb),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .bus_req      (bus_req),
        .bus_wr       (bus_wr),
        .bus_wstrb    (bus_wstrb),
        .bus_addr     (bus_addr),
        .bus_wdata    (bus_wdata),
        .bus_addr_ok  (bus_addr_ok),
        .bus_data_ok  (bus_data_ok),
        .bus_rdata    (bus_rdata),
        .bus_owner    (bus_owner)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    function automatic vec_t mkVec(input logic [4:0] in, input logic [5:0] exp);
        vec_t v;
        v.rst  = in[4];
        v.ireq = in[3];
        v.dreq = in[2];
        v.aok  = in[1];
        v.dok  = in[0];
        v.exp  = exp;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input vec_t v);
        rst         = v.rst;
        inst_req    = v.ireq;
        data_req    = v.dreq;
        bus_addr_ok = v.aok;
        bus_data_ok = v.dok;
        #1;
    endtask

    task automatic clearInputs();
        rst         = 1'b0;
        inst_req    = 1'b0;
        data_req    = 1'b0;
        bus_addr_ok = 1'b0;
        bus_data_ok = 1'b0;
        bus_rdata   = 32'h0;
    endtask

    task automatic doReset();
        clearInputs();
        rst = 1'b1;
        stepCycle();
        rst = 1'b0;
        #1;
    endtask

    function automatic logic [5:0] flags();
        return {bus_req, inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok, bus_owner};
    endfunction

    initial begin
        logic [1:0]  st;
        logic [11:0] grants;
        logic [11:0] exp_grants;
        int          n;

        clearInputs();
        inst_addr  = 32'hBFC0_0000;
        data_wr    = 1'b1;
        data_wstrb = 4'b0100;
        data_addr  = 32'h8000_1002;
        data_wdata = 32'h5A5A_5A5A;
        rst        = 1'b1;
        stepCycle();
        stepCycle();

        // in = {rst, inst_req, data_req, bus_addr_ok, bus_data_ok}
        tbl[0]  = mkVec(5'b10000, 6'b000000);
        tbl[1]  = mkVec(5'b01000, 6'b000000);
        tbl[2]  = mkVec(5'b01010, 6'b110000);
        tbl[3]  = mkVec(5'b00001, 6'b001000);
        tbl[4]  = mkVec(5'b00001, 6'b000000);
        tbl[5]  = mkVec(5'b00100, 6'b000000);
        tbl[6]  = mkVec(5'b00101, 6'b100001);
        tbl[7]  = mkVec(5'b00110, 6'b100101);
        tbl[8]  = mkVec(5'b00010, 6'b000001);
        tbl[9]  = mkVec(5'b00001, 6'b000011);
        tbl[10] = mkVec(5'b00000, 6'b000001);
        tbl[11] = mkVec(5'b10000, 6'b000000);
        tbl[12] = mkVec(5'b00000, 6'b000000);

        for (int i = 0; i < 13; i++) begin
            applyStimulus(tbl[i]);
            checkOutput($sformatf("row%0d flags", i), 32'(flags()), 32'(tbl[i].exp));
            stepCycle();
        end

        // Single fetch read: inst must force write fields low even though the
        // data port presents a store.
        doReset();
        data_wstrb = 4'b1111;
        inst_req   = 1'b1;
        stepCycle();
        bus_addr_ok = 1'b1;
        #1;
        checkOutput("inst bus_req", 32'(bus_req), 32'd1);
        checkOutput("inst bus_addr", bus_addr, 32'hBFC0_0000);
        checkOutput("inst bus_wr", 32'(bus_wr), 32'd0);
        checkOutput("inst bus_wstrb", 32'(bus_wstrb), 32'd0);
        checkOutput("inst addr_ok", 32'(inst_addr_ok), 32'd1);
        stepCycle();
        inst_req    = 1'b0;
        bus_addr_ok = 1'b0;
        bus_data_ok = 1'b1;
        bus_rdata   = 32'h3C08_0001;
        #1;
        checkOutput("inst wait bus_req", 32'(bus_req), 32'd0);
        checkOutput("inst data_ok", 32'(inst_data_ok), 32'd1);
        checkOutput("inst rdata", inst_rdata, 32'h3C08_0001);
        checkOutput("inst no data pulses", 32'({data_addr_ok, data_data_ok}), 32'd0);
        stepCycle();
        bus_data_ok = 1'b0;
        #1;
        checkOutput("inst bus_req done", 32'(bus_req), 32'd0);

        // Store: one stalled REQ cycle then acceptance; fields must hold.
        data_wstrb = 4'b0100;
        data_req   = 1'b1;
        stepCycle();
        for (int c = 0; c < 2; c++) begin
            bus_addr_ok = (c == 1);
            #1;
            checkOutput($sformatf("store%0d bus_req", c), 32'(bus_req), 32'd1);
            checkOutput($sformatf("store%0d bus_wr", c), 32'(bus_wr), 32'd1);
            checkOutput($sformatf("store%0d bus_wstrb", c), 32'(bus_wstrb), 32'h4);
            checkOutput($sformatf("store%0d bus_addr", c), bus_addr, 32'h8000_1002);
            checkOutput($sformatf("store%0d bus_wdata", c), bus_wdata, 32'h5A5A_5A5A);
            checkOutput($sformatf("store%0d bus_owner", c), 32'(bus_owner), 32'd1);
            checkOutput($sformatf("store%0d data_addr_ok", c), 32'(data_addr_ok), 32'(c == 1));
            stepCycle();
        end
        data_req    = 1'b0;
        bus_addr_ok = 1'b0;
        bus_data_ok = 1'b1;
        #1;
        checkOutput("store data_ok", 32'(data_data_ok), 32'd1);
        stepCycle();
        clearInputs();

        // Grant lock: fetch owns REQ while addr_ok stalls and data_req rises.
        doReset();
        inst_req = 1'b1;
        stepCycle();
        data_req = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            checkOutput($sformatf("lock%0d owner", c), 32'(bus_owner), 32'd0);
            checkOutput($sformatf("lock%0d addr_oks", c), 32'({inst_addr_ok, data_addr_ok}), 32'd0);
            checkOutput($sformatf("lock%0d bus_addr", c), bus_addr, 32'hBFC0_0000);
            stepCycle();
        end
        bus_addr_ok = 1'b1;
        #1;
        checkOutput("lock accept", 32'({inst_addr_ok, data_addr_ok}), 32'b10);
        stepCycle();
        inst_req    = 1'b0;
        bus_addr_ok = 1'b0;
        bus_data_ok = 1'b1;
        #1;
        checkOutput("lock inst data_ok", 32'(inst_data_ok), 32'd1);
        stepCycle();
        bus_data_ok = 1'b0;
        #1;
        checkOutput("lock rearb to data", 32'({bus_req, bus_owner}), 32'b11);
        clearInputs();

        // Starvation: both ports request continuously on a zero-wait bus.
        doReset();
        inst_req    = 1'b1;
        data_req    = 1'b1;
        bus_addr_ok = 1'b1;
        bus_data_ok = 1'b1;
        #1;
        n          = 0;
        grants     = '0;
        exp_grants = 12'b1111_0111_1011;
        for (int c = 0; c < 60 && n < 12; c++) begin
            if (bus_req) begin
                grants[11 - n] = bus_owner;
                n++;
            end
            stepCycle();
        end
        checkOutput("starve grant count", 32'(n), 32'd12);
        for (int g = 0; g < 12; g++) begin
            checkOutput($sformatf("starve grant%0d owner", g), 32'(grants[11 - g]), 32'(exp_grants[11 - g]));
        end
        clearInputs();

        // Back-to-back data on a zero-wait bus: bus_req every other cycle.
        doReset();
        data_req    = 1'b1;
        bus_addr_ok = 1'b1;
        bus_data_ok = 1'b1;
        #1;
        for (int c = 0; c < 10; c++) begin
            checkOutput($sformatf("b2b%0d bus_req", c), 32'(bus_req), 32'(c % 2));
            checkOutput($sformatf("b2b%0d data_addr_ok", c), 32'(data_addr_ok), 32'(c % 2));
            checkOutput($sformatf("b2b%0d inst pulses", c), 32'({inst_addr_ok, inst_data_ok}), 32'd0);
            stepCycle();
        end
        clearInputs();

        // Reset in WAIT with a response in the same cycle, then a stray
        // response two cycles after release.
        doReset();
        inst_req    = 1'b1;
        data_req    = 1'b1;
        bus_addr_ok = 1'b1;
        stepCycle();
        stepCycle();
        inst_req    = 1'b0;
        data_req    = 1'b0;
        bus_addr_ok = 1'b0;
        #1;
        checkOutput("rst pre starve_cnt", 32'(dut.starve_cnt), 32'd1);
        rst         = 1'b1;
        bus_data_ok = 1'b1;
        #1;
        checkOutput("rst same-cycle data_ok", 32'({inst_data_ok, data_data_ok}), 32'd0);
        stepCycle();
        rst         = 1'b0;
        bus_data_ok = 1'b0;
        stepCycle();
        stepCycle();
        bus_data_ok = 1'b1;
        #1;
        checkOutput("stray data_ok", 32'({inst_data_ok, data_data_ok}), 32'd0);
        checkOutput("stray bus_req", 32'(bus_req), 32'd0);
        stepCycle();
        bus_data_ok = 1'b0;
        st = dut.state;
        checkOutput("stray state idle", 32'(st), 32'd0);
        checkOutput("stray starve_cnt", 32'(dut.starve_cnt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Shares a single SRAM-like CPU bus, one outstanding transaction at a time, between the instruction-fetch port and the data-access port. The data port is the request side of the memory stage that produces `data_sram_en/wen/addr/wdata`. The block latches a winner, presents its request on the bus, routes `addr_ok`/`data_ok`/`rdata` back to that winner only, and bounds instruction starvation with a consecutive-data-grant counter. It sits between the pipeline fetch/memory stages and the cache/AXI bridge.

## Interface
- `STARVE_LIMIT`, 4, maximum number of consecutive data grants allowed while `inst_req` is pending; must be ≥ 1.
- `clk` input 1: the single clock.
- `rst` input 1: reset, synchronous and active-high.
- `inst_req` input 1: fetch request; held until `inst_addr_ok`.
- `inst_addr` input 32: fetch address; stable while `inst_req` is high.
- `inst_addr_ok` output 1: one-cycle pulse, fetch request accepted by the bus.
- `inst_data_ok` output 1: one-cycle pulse, fetch data valid.
- `inst_rdata` output 32: equals `bus_rdata`; meaningful only with `inst_data_ok`.
- `data_req` input 1: load/store request; held until `data_addr_ok`.
- `data_wr` input 1: 1 = store.
- `data_wstrb` input 4: byte enables (the `data_sram_wen` encoding).
- `data_addr` input 32: access address.
- `data_wdata` input 32: store data, already lane-replicated by the memory stage.
- `data_addr_ok` output 1: one-cycle pulse, data request accepted.
- `data_data_ok` output 1: one-cycle pulse, load data valid or store complete.
- `data_rdata` output 32: equals `bus_rdata`; meaningful only with `data_data_ok`.
- `bus_req` output 1: request to the downstream bus.
- `bus_wr` output 1: write flag.
- `bus_wstrb` output 4: byte strobes.
- `bus_addr` output 32: address.
- `bus_wdata` output 32: write data.
- `bus_addr_ok` input 1: downstream request accepted.
- `bus_data_ok` input 1: downstream response.
- `bus_rdata` input 32: downstream read data.
- `bus_owner` output 1: 0 = inst, 1 = data; the current or last granted port.

## Operation
- The FSM has three states: IDLE, REQ and WAIT. The block also holds an `owner` register and a `starve_cnt` counter of width clog2(STARVE_LIMIT+1).
- **Arbitration** runs at the edge that leaves IDLE, and at the edge that leaves WAIT on `bus_data_ok`.
  - Only `data_req` high: data wins.
  - Only `inst_req` high: inst wins.
  - Both high: data wins unless `starve_cnt == STARVE_LIMIT`, in which case inst wins.
- **starve_cnt update**:
  - Data grant with `inst_req` high: increment, saturating at STARVE_LIMIT.
  - Data grant with `inst_req` low: clear.
  - Inst grant: clear.
- **IDLE**
  - Any request: latch `owner`, go to REQ.
  - No request: stay in IDLE.
  - All bus outputs are 0.
- **REQ**
  - `bus_req` = 1.
  - `bus_addr`, `bus_wr`, `bus_wstrb`, `bus_wdata` are muxed combinationally from the owner's inputs.
  - Inst owner forces `bus_wr` = 0 and `bus_wstrb` = 0000.
  - `owner_addr_ok` = `bus_addr_ok`, same cycle.
  - On `bus_addr_ok`, go to WAIT.
  - The grant is locked: the owner does not change while REQ waits, even if the other port raises a request.
- **WAIT**
  - `bus_req` = 0; this enforces a single outstanding transaction.
  - `owner_data_ok` = `bus_data_ok`, same cycle.
  - On `bus_data_ok`: re-arbitrate and go to REQ if any request is present, otherwise go to IDLE.
- **Gating and stray responses**
  - The non-owner's `addr_ok` and `data_ok` are always 0.
  - `bus_data_ok` in IDLE or REQ is a stray response. It is ignored and not forwarded.
  - `bus_addr_ok` outside REQ is ignored.
- **Reset**
  - Outputs: `bus_req` = 0, all `*_addr_ok`/`*_data_ok` = 0, `bus_addr`/`bus_wdata`/`bus_wstrb`/`bus_wr` = 0, `bus_owner` = 0.
  - State: IDLE, `starve_cnt` = 0.
  - Reset mid-transaction abandons it. Any later response is stray and dropped.

## Timing
- Arbitration latency: a request at edge t in IDLE gives `bus_req` high during cycle t+1.
- `addr_ok` is combinational from the bus, so it can arrive the same cycle as `bus_req` (earliest t+1). `data_ok` is also combinational from the bus and can arrive at the earliest one cycle after acceptance (t+2).
- Back-to-back: `bus_data_ok` in cycle k with a request pending gives `bus_req` in cycle k+1. Throughput is one transaction per 2 cycles with a zero-wait bus.
- Simultaneous events:
  - `bus_data_ok` and a new request from the same port in the same cycle: the new request is eligible in that arbitration.
  - `rst` with `bus_data_ok` in the same cycle: `rst` wins and nothing is forwarded.
- `rdata` is not registered. Requesters capture it on their `data_ok`.

## Test plan
- **Single inst read**: `inst_req` with addr 0xBFC00000, bus `addr_ok` in the first REQ cycle, `data_ok` 1 cycle later with 0x3C080001. Required: `bus_req` for exactly 1 cycle, `inst_addr_ok` 1 pulse, `inst_data_ok` 1 pulse carrying 0x3C080001, `data_*` pulses all 0.
- **Store**: `data_req`, `wr` = 1, `wstrb` 0100, addr 0x80001002, `wdata` 0x5A5A5A5A. Required: bus fields identical during REQ and `bus_owner` = 1.
- **Starvation**: hold both requests for 12 transactions with `STARVE_LIMIT` = 4. Required grant order: D D D D I D D D D I D D.
- **Grant lock**: inst in REQ with `addr_ok` stalled 3 cycles, `data_req` rises meanwhile. Required: inst stays owner and is accepted first.
- **Stray and reset**: assert `rst` in WAIT, then `bus_data_ok` 2 cycles after release. Required: no `*_data_ok` pulse, state IDLE, `starve_cnt` = 0.
- **Back-to-back**: zero-wait bus with data requests continuously. Required: `bus_req` asserted every other cycle, data requests only with no inst pending.
